// File: rtl/nibble_serial_alu_if.sv
// Bus between the control-word side and the nibble-serial ALU sequencer.
// Handshake: an operation is accepted on a rising clk edge where start=1 and
// ready=1; opa/opb/op are sampled on that edge only. done is a one-cycle pulse
// marking result and flags valid; start while ready=0 is ignored, not queued.
interface nibble_serial_alu_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         carry_flag;
    logic         zero_flag;
    logic         ovf_flag;

    modport master (
        output start, op, opa, opb,
        input  ready, done, result, carry_flag, zero_flag, ovf_flag
    );

    modport slave (
        input  start, op, opa, opb,
        output ready, done, result, carry_flag, zero_flag, ovf_flag
    );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-nibble add/subtract sequencer that time-shares one external 4-bit
// adder, LSB nibble first, rippling the carry through a register.
// op: 00 ADD, 01 SUB, 10 ADC, 11 SBB. op[0] inverts B; op[1] takes the
// initial carry from carry_flag instead of from op[0].
module nibble_serial_alu_ctrl #(
    parameter int NIBBLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_alu_if.slave      bus,
    output logic [3:0]              adder_a,
    output logic [3:0]              adder_b,
    output logic                    adder_cin,
    input  logic [3:0]              adder_sum,
    input  logic                    adder_cout,
    output logic [1:0]              dbg_state_o
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            inv_q;
    logic            carry_q;
    logic            ready_q;
    logic            done_q;
    logic [W-1:0]    result_q;
    logic            carry_flag_q;
    logic            zero_flag_q;
    logic            ovf_flag_q;

    logic [IDXW+1:0] sel;
    logic [W-1:0]    result_d;
    logic            ovf_d;
    logic            last_nibble;

    assign sel         = {idx_q, 2'b00};
    assign last_nibble = (idx_q == LAST_IDX);

    // Drive the shared adder from registered operands; idle the adder outside RUN.
    always_comb begin
        adder_a   = 4'h0;
        adder_b   = 4'h0;
        adder_cin = 1'b0;
        if (state_q == ST_RUN) begin
            adder_a   = a_q[sel +: 4];
            adder_b   = b_q[sel +: 4] ^ {4{inv_q}};
            adder_cin = carry_q;
        end
    end

    // Result with the current adder nibble merged in, plus signed overflow of the top nibble.
    always_comb begin
        result_d           = result_q;
        result_d[sel +: 4] = adder_sum;
        ovf_d = (a_q[W-1] == (b_q[W-1] ^ inv_q)) && (adder_sum[3] != a_q[W-1]);
    end

    // Sequencer FSM: accept in IDLE, one nibble per cycle in RUN, one-cycle DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            inv_q        <= 1'b0;
            carry_q      <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            result_q     <= '0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
            ovf_flag_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.opa;
                        b_q     <= bus.opb;
                        inv_q   <= bus.op[0];
                        idx_q   <= '0;
                        // ADD:0, SUB:1, ADC/SBB: chain from the previous carry flag.
                        carry_q <= bus.op[1] ? carry_flag_q : bus.op[0];
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    carry_q  <= adder_cout;
                    idx_q    <= idx_q + 1'b1;
                    if (last_nibble) begin
                        carry_flag_q <= adder_cout;
                        ovf_flag_q   <= ovf_d;
                        zero_flag_q  <= (result_d == '0);
                        idx_q        <= '0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.carry_flag = carry_flag_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.ovf_flag   = ovf_flag_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl: directed test-plan steps plus randomized
// operations, checked against a whole-word arithmetic reference model.
module tb_nibble_serial_alu_ctrl;
    localparam int NIBBLES = 2;
    localparam int W       = 4 * NIBBLES;
    localparam int PERIOD  = NIBBLES + 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] adder_a;
    logic [3:0] adder_b;
    logic       adder_cin;
    logic [3:0] adder_sum;
    logic       adder_cout;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic model_cf = 1'b0;
    // Expected {ovf, zero, carry, result} per accepted operation.
    logic [W+2:0] exp_q[$];

    nibble_serial_alu_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_cin   (adder_cin),
        .adder_sum   (adder_sum),
        .adder_cout  (adder_cout),
        .dbg_state_o (dbg_state)
    );

    // External 4-bit adder the sequencer time-shares.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-word add of A, optionally inverted B, and the initial carry.
    function automatic logic [W+2:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cf);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         c0;
        logic [W-1:0] r;
        logic         ovf;
        bb   = op[0] ? ~b : b;
        c0   = op[1] ? cf : op[0];
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        r    = full[W-1:0];
        ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {ovf, (r == '0), full[W], r};
    endfunction

    // Carry entering nibble i: carry out of the low 4*i bits of the full-width sum.
    function automatic logic nib_cin(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cf, input int i);
        logic [63:0] mask;
        logic [63:0] low;
        logic [W-1:0] bb;
        logic c0;
        bb   = op[0] ? ~b : b;
        c0   = op[1] ? cf : op[0];
        mask = (64'd1 << (4 * i)) - 64'd1;
        low  = (64'(a) & mask) + (64'(bb) & mask) + 64'(c0);
        return low[4 * i];
    endfunction

    task automatic check_outputs(input string tag, input logic [W+2:0] e);
        chk({tag, "_result"}, 64'(bus.result), 64'(e[W-1:0]));
        chk({tag, "_carry"},  64'(bus.carry_flag), 64'(e[W]));
        chk({tag, "_zero"},   64'(bus.zero_flag), 64'(e[W+1]));
        chk({tag, "_ovf"},    64'(bus.ovf_flag), 64'(e[W+2]));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_idle"}, 64'(bus.ready), 64'd1);
    endtask

    // Driver: one full operation, checking adder drive per nibble and the done cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic [W+2:0] e;
        logic [W-1:0] bb;
        logic cf_at_accept;
        wait_ready(tag);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        cf_at_accept = model_cf;
        e = model(op, a, b, model_cf);
        exp_q.push_back(e);
        model_cf = e[W];
        bb = op[0] ? ~b : b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opa   = W'($urandom);
        bus.opb   = W'($urandom);
        bus.op    = 2'($urandom);
        for (int i = 0; i < NIBBLES; i++) begin
            @(negedge clk);
            chk({tag, "_run_ready"}, 64'(bus.ready), 64'd0);
            chk({tag, "_run_done"},  64'(bus.done), 64'd0);
            chk({tag, "_adder_a"},   64'(adder_a), 64'(a[4*i +: 4]));
            chk({tag, "_adder_b"},   64'(adder_b), 64'(bb[4*i +: 4]));
            chk({tag, "_adder_cin"}, 64'(adder_cin), 64'(nib_cin(op, a, b, cf_at_accept, i)));
        end
        @(negedge clk);
        chk({tag, "_done"},       64'(bus.done), 64'd1);
        chk({tag, "_done_ready"}, 64'(bus.ready), 64'd0);
        check_outputs(tag, exp_q.pop_front());
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},  64'(bus.ready), 64'd1);
        chk({tag, "_done"},   64'(bus.done), 64'd0);
        chk({tag, "_result"}, 64'(bus.result), 64'd0);
        chk({tag, "_flags"},  64'({bus.carry_flag, bus.zero_flag, bus.ovf_flag}), 64'd0);
        chk({tag, "_adder"},  64'({adder_a, adder_b, adder_cin}), 64'd0);
    endtask

    initial begin
        int dones;
        int nacc;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = '0;
        bus.opb   = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // Directed test-plan steps.
        do_op("add_3c_4a", 2'b00, 8'h3C, 8'h4A);
        do_op("sub_50_50", 2'b01, 8'h50, 8'h50);
        do_op("sub_10_20", 2'b01, 8'h10, 8'h20);
        do_op("sbb_00_00", 2'b11, 8'h00, 8'h00);
        do_op("add_ff_01", 2'b00, 8'hFF, 8'h01);
        do_op("adc_00_00", 2'b10, 8'h00, 8'h00);
        do_op("add_7f_01", 2'b00, 8'h7F, 8'h01);
        do_op("sub_80_01", 2'b01, 8'h80, 8'h01);

        // Randomized operations, including ADC/SBB chains through carry_flag.
        for (int k = 0; k < 40; k++) begin
            do_op("rand", 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        end

        // start held high: accepts only when ready, one done per PERIOD cycles.
        wait_ready("held");
        dones = 0;
        nacc  = 0;
        for (int j = 0; j < 5 * PERIOD; j++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W+2:0] e;
            if (j > 0) begin
                chk("held_done",  64'(bus.done),  64'((j % PERIOD) == PERIOD - 1));
                chk("held_ready", 64'(bus.ready), 64'((j % PERIOD) == 0));
                if (bus.done === 1'b1) begin
                    dones++;
                    if (exp_q.size() > 0) check_outputs("held", exp_q.pop_front());
                end
            end
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = W'($urandom);
            bus.start = 1'b1;
            bus.op    = op;
            bus.opa   = a;
            bus.opb   = b;
            if ((j % PERIOD) == 0) begin
                e = model(op, a, b, model_cf);
                model_cf = e[W];
                exp_q.push_back(e);
                nacc++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        // Last accept at j = 4*PERIOD completes inside the loop's final cycle.
        chk("held_done_count", 64'(dones), 64'(nacc));
        wait_ready("held_end");

        // Reset during the first RUN cycle aborts the operation.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opa   = 8'h12;
        bus.opb   = 8'h34;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_in_run", 64'(bus.ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        model_cf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 2 * PERIOD; j++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        do_op("after_abort", 2'b00, 8'h01, 8'h01);
        chk("leftover_exp", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
